// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_sync_ext #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        flush,
  input  logic                        clr_err,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int LOG = $clog2(FIFO_DEPTH);
  localparam int PW  = LOG + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic flush_en, wr_req, rd_req, wr_acc, rd_acc, clr_en;

  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == PW'(FIFO_DEPTH));
  assign almost_full  = (int'(level_q) >= AFULL_THRESH);
  assign almost_empty = (int'(level_q) <= AEMPTY_THRESH);
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign flush_en = cs & flush;
  assign clr_en   = cs & clr_err;
  assign wr_req   = cs & wr_en & ~flush;
  assign rd_req   = cs & rd_en & ~flush;
  assign rd_acc   = rd_req & ~fifo_empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc   = wr_req & (~fifo_full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + PW'(1);
        2'b01:   level_d = level_q - PW'(1);
        default: level_d = level_q;
      endcase
    end
    // Setting has priority over clearing in the same cycle.
    overflow_d  = (overflow_q  & ~clr_en) | (wr_req & ~wr_acc);
    underflow_d = (underflow_q & ~clr_en) | (rd_req & ~rd_acc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q[LOG-1:0]] <= data_in;
  end

  // The wrap bits keep the pointer distance equal to the occupancy counter.
  always_ff @(posedge clk) begin
    assert (rst || (level_q == PW'(wr_ptr_q - rd_ptr_q)));
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = mem_q[rd_ptr_q[LOG-1:0]];
    assign data_valid = ~fifo_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q;

    always_comb dout_d = rd_acc ? mem_q[rd_ptr_q[LOG-1:0]] : dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= rd_acc;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
  end

endmodule
